// File: rtl/pipe_pkg.sv
// Shared defaults and helpers for the generic pipeline-register chain.
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_STAGES = 4;
    localparam int DEF_CNT_W  = 16;

    // Increment that sticks at the all-ones value of a counter `width` bits wide (width <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Data-path handshake of the pipeline chain: stage-0 input, last-stage consumer and stage taps.
interface pipe_stage_chain_if #(
    parameter int DATA_W = 32,
    parameter int STAGES = 4
);
    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic                     in_ready;
    logic                     out_ready;
    logic [STAGES-1:0]        stage_valid;
    logic [STAGES*DATA_W-1:0] stage_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, stage_valid, stage_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, stage_valid, stage_data
    );
endinterface

// File: rtl/pipe_stage.sv
// One valid+payload pipeline register; flush beats hold beats bubble beats load.
module pipe_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              hold,
    input  logic              bubble,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (flush || (!hold && bubble)) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (!hold) begin
            // An empty slot always carries a zero payload so a bubble decodes as NOP.
            valid_reg <= load_valid;
            data_reg  <= load_valid ? load_data : '0;
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: rtl/pipe_stage_chain.sv
// Generic pipeline-register chain with stall/flush/backpressure and saturating counters.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int STAGES = DEF_STAGES,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    pipe_stage_chain_if.slave bus,
    input  logic [STAGES-1:0] stall,
    input  logic [STAGES-1:0] flush,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] bubble;
    logic [STAGES-1:0] valid_vec;
    logic [DATA_W-1:0] data_arr [STAGES];
    logic              retire_fire;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic [CNT_W-1:0]  retire_cnt_reg;

    // Hold propagates upstream; flush deliberately plays no part in it.
    always_comb begin
        hold       = '0;
        hold[LAST] = stall[LAST] | (valid_vec[LAST] & ~bus.out_ready);
        for (int i = LAST - 1; i >= 0; i--) begin
            hold[i] = stall[i] | hold[i + 1];
        end
    end

    always_comb begin
        bubble = '0;
        for (int i = 1; i < STAGES; i++) begin
            bubble[i] = hold[i - 1];
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic              load_valid;
        logic [DATA_W-1:0] load_data;

        if (gi == 0) begin : g_first
            assign load_valid = bus.in_valid;
            assign load_data  = bus.in_data;
        end else begin : g_rest
            assign load_valid = valid_vec[gi - 1];
            assign load_data  = data_arr[gi - 1];
        end

        pipe_stage #(
            .DATA_W(DATA_W)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush[gi]),
            .hold      (hold[gi]),
            .bubble    (bubble[gi]),
            .load_valid(load_valid),
            .load_data (load_data),
            .valid     (valid_vec[gi]),
            .data      (data_arr[gi])
        );
    end

    always_comb begin
        bus.stage_data = '0;
        for (int i = 0; i < STAGES; i++) begin
            bus.stage_data[i*DATA_W +: DATA_W] = data_arr[i];
        end
    end

    assign bus.stage_valid = valid_vec;
    assign bus.in_ready    = ~hold[0];
    assign retire_fire     = valid_vec[LAST] & ~hold[LAST] & ~flush[LAST];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg  <= '0;
            retire_cnt_reg <= '0;
        end else if (cnt_clear) begin
            stall_cnt_reg  <= '0;
            retire_cnt_reg <= '0;
        end else begin
            if (hold[0]) begin
                stall_cnt_reg <= CNT_W'(sat_inc(32'(stall_cnt_reg), CNT_W));
            end
            if (retire_fire) begin
                retire_cnt_reg <= CNT_W'(sat_inc(32'(retire_cnt_reg), CNT_W));
            end
        end
    end

    assign stall_cnt  = stall_cnt_reg;
    assign retire_cnt = retire_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed plus randomized check of pipe_stage_chain against a behavioural pipeline model.
module tb_pipe_stage_chain;

    localparam int DW   = 32;
    localparam int ST   = 4;
    localparam int CW   = 4;
    localparam int L    = ST - 1;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [ST-1:0] stall;
    logic [ST-1:0] flush;
    logic          cnt_clear;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] retire_cnt;

    int total = 0;
    int bad   = 0;

    pipe_stage_chain_if #(.DATA_W(DW), .STAGES(ST)) bus ();

    pipe_stage_chain #(
        .DATA_W(DW),
        .STAGES(ST),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .stall     (stall),
        .flush     (flush),
        .cnt_clear (cnt_clear),
        .stall_cnt (stall_cnt),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [ST-1:0] m_valid;
    logic [DW-1:0] m_data [ST];
    int            m_stall;
    int            m_retire;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A stage is frozen when anything at or below it stalls, or the full last stage is not drained.
    function automatic logic [ST-1:0] model_hold();
        logic [ST-1:0] h;
        logic          bp;
        bp = m_valid[L] && !bus.out_ready;
        for (int i = 0; i < ST; i++) begin
            h[i] = bp || ((stall >> i) != '0);
        end
        return h;
    endfunction

    function automatic logic [ST*DW-1:0] model_pack();
        logic [ST*DW-1:0] p;
        p = '0;
        for (int i = 0; i < ST; i++) p[i*DW +: DW] = m_data[i];
        return p;
    endfunction

    task automatic model_clear();
        m_valid  = '0;
        for (int i = 0; i < ST; i++) m_data[i] = '0;
        m_stall  = 0;
        m_retire = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":valid"},  128'(bus.stage_valid), 128'(m_valid));
        chk({tag, ":data"},   128'(bus.stage_data),  128'(model_pack()));
        chk({tag, ":ready"},  128'(bus.in_ready),    128'(!model_hold()[0]));
        chk({tag, ":stallc"}, 128'(stall_cnt),       128'(m_stall));
        chk({tag, ":retc"},   128'(retire_cnt),      128'(m_retire));
    endtask

    task automatic tick(input string tag);
        logic [ST-1:0] h;
        logic [ST-1:0] nv;
        logic [DW-1:0] nd [ST];
        h = model_hold();
        for (int i = 0; i < ST; i++) begin
            if (flush[i] || (!h[i] && i > 0 && h[i-1])) begin
                nv[i] = 1'b0;
                nd[i] = '0;
            end else if (h[i]) begin
                nv[i] = m_valid[i];
                nd[i] = m_data[i];
            end else if (i == 0) begin
                nv[i] = bus.in_valid;
                nd[i] = bus.in_valid ? bus.in_data : '0;
            end else begin
                nv[i] = m_valid[i-1];
                nd[i] = m_data[i-1];
            end
        end
        if (cnt_clear) begin
            m_stall  = 0;
            m_retire = 0;
        end else begin
            if (h[0] && m_stall < MAXC) m_stall++;
            if (m_valid[L] && !h[L] && !flush[L] && m_retire < MAXC) m_retire++;
        end
        @(posedge clk);
        #1;
        m_valid = nv;
        for (int i = 0; i < ST; i++) m_data[i] = nd[i];
        check_all(tag);
    endtask

    initial begin : main
        logic [DW-1:0] vals [4];
        int            saved;
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;

        reset = 1'b0; stall = '0; flush = '0; cnt_clear = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b1;

        // Four back-to-back items through an idle chain
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1; bus.in_data = vals[k];
            tick("fill");
            $display("fill item=%0h", vals[k]);
        end
        bus.in_valid = 1'b0; bus.in_data = '0;
        chk("first_at_s3", 128'(bus.stage_data[L*DW +: DW]), 128'(32'h11));
        for (int k = 1; k < 4; k++) begin
            tick("drain");
            chk("order_at_s3", 128'(bus.stage_data[L*DW +: DW]), 128'(vals[k]));
        end
        tick("drain");
        chk("retire4", 128'(retire_cnt), 128'(4));

        // Stall stage 1 for two cycles while the stream flows
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1; bus.in_data = 32'h100 + k;
            tick("pre_stall");
        end
        stall = 4'b0010;
        #1;
        chk("stall_ready", 128'(bus.in_ready), 128'(0));
        for (int k = 0; k < 2; k++) begin
            tick("stall1");
            chk("stall1_bubble", 128'({bus.stage_valid[2], bus.stage_data[2*DW +: DW]}), 128'(0));
        end
        chk("stallcnt2", 128'(stall_cnt), 128'(2));
        stall = '0;
        $display("stall1 done stall_cnt=%0d", stall_cnt);

        // Branch-taken flush of stages 0 and 1
        bus.in_data = 32'h200; tick("pre_flush");
        flush = 4'b0011; bus.in_data = 32'h201;
        tick("flush01");
        chk("flush01_valid", 128'(bus.stage_valid[1:0]), 128'(0));
        flush = '0;
        $display("flush01 done");

        // Backpressure freezes the whole chain
        bus.in_data = 32'h300; tick("pre_bp");
        bus.in_data = 32'h301; tick("pre_bp");
        bus.out_ready = 1'b0;
        saved = m_retire;
        for (int k = 0; k < 3; k++) begin
            bus.in_data = 32'h310 + k;
            tick("bp");
        end
        chk("bp_ready", 128'(bus.in_ready), 128'(0));
        chk("bp_retire", 128'(retire_cnt), 128'(saved));
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick("bp_release");
        $display("backpressure done retire_cnt=%0d", retire_cnt);

        // Stall and flush of stage 2 together
        stall = 4'b0100; flush = 4'b0100; bus.in_data = 32'h400;
        tick("stallflush2");
        chk("sf2_s2", 128'(bus.stage_valid[2]), 128'(0));
        chk("sf2_s3", 128'(bus.stage_valid[3]), 128'(0));
        stall = '0; flush = '0;
        $display("stall+flush stage2 done");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bus.in_valid  = 1'($urandom_range(0, 3) != 0);
            bus.in_data   = $urandom;
            bus.out_ready = 1'($urandom_range(0, 4) != 0);
            for (int i = 0; i < ST; i++) begin
                stall[i] = 1'($urandom_range(0, 9) == 0);
                flush[i] = 1'($urandom_range(0, 14) == 0);
            end
            cnt_clear = 1'($urandom_range(0, 49) == 0);
            tick("rand");
            $display("rand n=%0d valid=%b in_ready=%b stall_cnt=%0d retire_cnt=%0d",
                     n, bus.stage_valid, bus.in_ready, stall_cnt, retire_cnt);
        end
        stall = '0; flush = '0; cnt_clear = 1'b0; bus.out_ready = 1'b1;

        // Stall counter saturation and clear
        stall = 4'b0001;
        for (int k = 0; k < (1 << CW) + 5; k++) tick("sat");
        chk("stall_sat", 128'(stall_cnt), 128'(MAXC));
        stall = '0; cnt_clear = 1'b1;
        tick("clear");
        chk("stall_clear", 128'(stall_cnt), 128'(0));
        chk("retire_clear", 128'(retire_cnt), 128'(0));
        cnt_clear = 1'b0;
        $display("saturation/clear done");

        // Asynchronous reset in the middle of a stream
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1; bus.in_data = 32'h500 + k;
            tick("pre_rst");
        end
        #3 reset = 1'b0;
        #1;
        model_clear();
        chk("rst_mid_valid", 128'(bus.stage_valid), 128'(0));
        check_all("rst_mid");
        #1 reset = 1'b1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick("post_rst");
        $display("mid-stream reset done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised pipeline-register chain replacing the hand-written IF/ID, ID/EX, EX/MEM and MEM/WB buffers of the MIPS32 core with one generic block. Carries a DATA_W payload plus a valid bit through STAGES registers, with per-stage stall (freeze upstream, bubble downstream), per-stage flush, last-stage backpressure and saturating performance counters. Sits between the fetch unit and write-back; control, hazard and branch logic drive its stall/flush vectors.

## Interface
- DATA_W, 32, payload width per stage (IR, PC and control bits packed by the instantiating core)
- STAGES, 4, number of register stages (≥1)
- CNT_W, 16, width of each performance counter
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- in_valid  in  1  stage-0 input holds a valid item
- in_data  in  DATA_W  stage-0 input payload
- in_ready  out  1  stage 0 accepts this cycle (= ~hold[0])
- stall  in  STAGES  stall[i]: stage i must keep its contents
- flush  in  STAGES  flush[i]: stage i becomes a bubble next edge
- out_ready  in  1  consumer of last stage accepts
- stage_valid  out  STAGES  valid bit of every stage register
- stage_data  out  STAGES*DATA_W  payload of every stage, stage i at bits [i*DATA_W +: DATA_W]
- cnt_clear  in  1  synchronous clear of both counters
- stall_cnt  out  CNT_W  cycles with in_ready low
- retire_cnt  out  CNT_W  items leaving last stage

## Operation
- Hold chain (combinational): hold[STAGES-1] = stall[STAGES-1] | (stage_valid[STAGES-1] & ~out_ready); hold[i] = stall[i] | hold[i+1] for i < STAGES-1.
- Per stage i, next state, priority highest first:
  - flush[i]: valid←0, data←0 (zero = NOP), regardless of hold.
  - hold[i]: valid, data unchanged.
  - i>0 and hold[i-1]: bubble, valid←0, data←0.
  - else load: stage 0 from in_valid/in_data; stage i from stage i-1.
- Stage 0 with in_valid=0 and not held loads a bubble (valid 0, data 0).
- stall_cnt: +1 each cycle hold[0]=1; saturates at 2^CNT_W−1.
- retire_cnt: +1 each cycle stage_valid[STAGES-1] & ~hold[STAGES-1] & ~flush[STAGES-1]; saturates.
- cnt_clear has priority over increment; counters read 0 the next cycle.
- Flush of a stage that is also held frees the slot but keeps upstream frozen that cycle (hold is computed without regard to flush).

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream): stage_valid=0, stage_data=0, stall_cnt=0, retire_cnt=0; in_ready reflects hold[0] combinationally (1 after reset if stall=0).
- Latency: item accepted at edge k appears in stage i after edge k+i (visible on stage_data during cycle k+i+1 relative to acceptance cycle); STAGES cycles to last stage with no stalls.
- Throughput: one item per cycle with no stall/backpressure.
- in_ready, hold vector: combinational from stall, out_ready, stage_valid[last]; no comb path from in_valid/in_data to any output.
- Reset asserted mid-operation: all items discarded immediately; no partial state survives.
- Simultaneous stall[i] and flush[i]: stage i cleared, stages < i frozen, stage i+1 gets bubble.

## Structure
- Shared package pipe_pkg: default DATA_W/STAGES/CNT_W constants and the saturating-increment function used by both counters.
- One sub-module, pipe_stage: single valid+data register with flush/hold/bubble/load priority; instantiated STAGES times in a generate loop. Hold chain and counters live in pipe_stage_chain.

## Test plan
- Reset then in_valid=1, in_data=0x11,0x22,0x33,0x44 on consecutive cycles, STAGES=4 -> 0x11 at stage 3 after 4 edges, then 0x22, 0x33, 0x44 on following cycles; retire_cnt=4.
- stall[1]=1 for 2 cycles with stream flowing -> stages 0,1 frozen, in_ready=0, stage 2 shows bubble (valid 0, data 0) for 2 cycles; stall_cnt=2; no item lost or duplicated.
- flush[0]=flush[1]=1 for one cycle (branch taken) -> both stages valid 0/data 0 next cycle; stages 2,3 advance normally.
- out_ready=0 with last stage valid -> whole chain freezes, in_ready=0, retire_cnt unchanged; release -> resumes in order.
- stall[2] and flush[2] same cycle -> stage 2 cleared, stages 0–1 held, stage 3 bubble.
- Force stall[0]=1 for 2^CNT_W+5 cycles (CNT_W=4 build) -> stall_cnt saturates at 15; cnt_clear pulse -> 0 next cycle; reset pulse mid-stream -> all valid 0 immediately.
